// File: rtl/crc_stream_engine.sv
// Bit-serial streaming CRC generator/checker: folds DATA_W-bit words MSB first into a CRC_W remainder.
// Latency: last word accepted at edge T -> crc_valid pulses in the cycle after edge T+DATA_W-1.
// Backpressure: in_ready drops for DATA_W-1 cycles after every accept while the word is shifted in.
module crc_stream_engine #(
  parameter int                CRC_W   = 8,
  parameter int                DATA_W  = 8,
  parameter logic [CRC_W-1:0]  POLY    = CRC_W'(8'h07),
  parameter logic [CRC_W-1:0]  INIT    = '0,
  parameter logic [CRC_W-1:0]  XOR_OUT = '0,
  parameter logic [CRC_W-1:0]  RESIDUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              busy,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_ok,
  output logic              crc_valid
);

  // The counter only ever holds DATA_W-1 down to 0; keep it at least one bit wide
  // so the DATA_W = 1 build still elaborates.
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [CRC_W-1:0]   rem, rem_d;
  logic [CRC_W-1:0]   rem_fold;
  logic [DATA_W-1:0]  sreg, sreg_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               last_q, last_d;
  logic               fold;
  logic               fold_bit;
  logic               fin;

  // One non-reflected CRC bit step.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r, input logic b);
    logic fb;
    fb = r[CRC_W-1] ^ b;
    return {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  // A word can only be taken while no earlier word is still being shifted in.
  assign in_ready = (state != SHIFT);
  assign busy     = (state != IDLE);

  // Next-state logic: pick the bit to fold this edge and detect the frame-end edge.
  always_comb begin
    state_d  = state;
    rem_d    = rem;
    sreg_d   = sreg;
    cnt_d    = cnt;
    last_d   = last_q;
    fold     = 1'b0;
    fold_bit = 1'b0;
    fin      = 1'b0;
    rem_fold = rem;

    if (clr) begin
      // Abort wins over any word presented in the same cycle.
      state_d = IDLE;
      sreg_d  = '0;
      cnt_d   = '0;
      last_d  = 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (in_valid) begin
            // The MSB is folded on the accept edge itself; the rest go to the shifter.
            fold     = 1'b1;
            fold_bit = in_data[DATA_W-1];
            if (DATA_W == 1) begin
              fin     = in_last;
              state_d = in_last ? IDLE : GAP;
            end else begin
              sreg_d  = in_data << 1;
              cnt_d   = CNT_W'(DATA_W - 1);
              last_d  = in_last;
              state_d = SHIFT;
            end
          end
        end
        SHIFT: begin
          fold     = 1'b1;
          fold_bit = sreg[DATA_W-1];
          sreg_d   = sreg << 1;
          cnt_d    = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            // Final bit of this word: either the frame closes or we wait for more.
            fin     = last_q;
            state_d = last_q ? IDLE : GAP;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    rem_fold = crc_step(rem, fold_bit);

    if (clr) begin
      rem_d = INIT;
    end else if (fold) begin
      // Frame end re-arms the remainder so the next frame starts clean.
      rem_d = fin ? INIT : rem_fold;
    end
  end

  // Frame state, remainder and shifter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rem    <= INIT;
      sreg   <= '0;
      cnt    <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= state_d;
      rem    <= rem_d;
      sreg   <= sreg_d;
      cnt    <= cnt_d;
      last_q <= last_d;
    end
  end

  // Result registers: loaded only at frame end and held otherwise (clr leaves them alone).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_out   <= '0;
      crc_ok    <= 1'b0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= fin;
      if (fin) begin
        crc_out <= rem_fold ^ XOR_OUT;
        crc_ok  <= (rem_fold == RESIDUE);
      end
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: three instances (CRC-8/byte, CRC-16 CCITT/byte, CRC-8/bit-serial).
// A timestamp-based model predicts every output each cycle from accepted words.
// Randomized frames and gaps plus directed abort/reset/back-to-back cases.
module tb_crc_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  clr, vld, lst;
  logic [31:0] din [3];
  logic [2:0]  rdy, bsy, cv, ok;
  logic [7:0]  o0, o2;
  logic [15:0] o1;
  logic [31:0] ov [3];

  assign ov[0] = {24'd0, o0};
  assign ov[1] = {16'd0, o1};
  assign ov[2] = {24'd0, o2};

  crc_stream_engine #(.CRC_W(8), .DATA_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .RESIDUE(8'h00)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .in_data(din[0][7:0]), .in_valid(vld[0]), .in_last(lst[0]),
    .in_ready(rdy[0]), .busy(bsy[0]), .crc_out(o0), .crc_ok(ok[0]), .crc_valid(cv[0]));

  crc_stream_engine #(.CRC_W(16), .DATA_W(8), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000), .RESIDUE(16'h0000)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .in_data(din[1][7:0]), .in_valid(vld[1]), .in_last(lst[1]),
    .in_ready(rdy[1]), .busy(bsy[1]), .crc_out(o1), .crc_ok(ok[1]), .crc_valid(cv[1]));

  crc_stream_engine #(.CRC_W(8), .DATA_W(1), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .RESIDUE(8'h00)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr[2]), .in_data(din[2][0]), .in_valid(vld[2]), .in_last(lst[2]),
    .in_ready(rdy[2]), .busy(bsy[2]), .crc_out(o2), .crc_ok(ok[2]), .crc_valid(cv[2]));

  // Per-instance configuration as seen by the model.
  int          CW [3] = '{8, 16, 8};
  int          DW [3] = '{8, 8, 1};
  logic [31:0] PL [3] = '{32'h07, 32'h1021, 32'h07};
  logic [31:0] IN [3] = '{32'h0, 32'hFFFF, 32'h0};
  logic [31:0] XO [3] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] RS [3] = '{32'h0, 32'h0, 32'h0};

  int nvec = 0;
  int nerr = 0;

  // Model state: k = number of clock edges seen; timing is kept as edge timestamps.
  int          k = 0;
  int          ready_from [3] = '{0, 0, 0};
  int          end_edge   [3] = '{-1, -1, -1};
  bit          open_f     [3] = '{0, 0, 0};
  bit          ev         [3] = '{0, 0, 0};
  logic [31:0] eo         [3] = '{0, 0, 0};
  bit          eok        [3] = '{0, 0, 0};
  logic [31:0] fw [3][64];
  int          fn [3] = '{0, 0, 0};

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[dut%0d] at edge %0d: got %0h, expected %0h", nm, d, k, act, exp);
    end
  endtask

  task automatic timeout(input string nm, input int d);
    nvec++;
    nerr++;
    $display("FAIL %s[dut%0d] at edge %0d: bound expired", nm, d, k);
  endtask

  // CRC of a word list by the textbook bitwise definition (MSB first, no reflection).
  function automatic logic [31:0] crc_of(input int cw, input logic [31:0] poly, input logic [31:0] init,
                                         input int dw, input logic [31:0] w [64], input int n);
    logic [31:0] r, m;
    logic        fb;
    m = (cw == 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    r = init;
    for (int i = 0; i < n; i++)
      for (int j = dw - 1; j >= 0; j--) begin
        fb = r[cw-1] ^ w[i][j];
        r  = (r << 1) & m;
        if (fb) r = r ^ poly;
      end
    return r;
  endfunction

  function automatic logic [31:0] ref_crc(input int d);
    logic [31:0] tmp [64];
    for (int i = 0; i < 64; i++) tmp[i] = fw[d][i];
    return crc_of(CW[d], PL[d], IN[d], DW[d], tmp, fn[d]);
  endfunction

  // Model: advance on every rising edge from the inputs the bench is driving.
  initial forever begin
    logic [31:0] r;
    @(posedge clk);
    k++;
    for (int d = 0; d < 3; d++) begin
      ev[d] = 1'b0;
      if (!rst_n) begin
        ready_from[d] = k; end_edge[d] = -1; open_f[d] = 1'b0; fn[d] = 0; eo[d] = 0; eok[d] = 1'b0;
      end else if (clr[d]) begin
        ready_from[d] = k; end_edge[d] = -1; open_f[d] = 1'b0; fn[d] = 0;
      end else begin
        if (vld[d] && (k - 1 >= ready_from[d])) begin
          if (fn[d] < 64) begin
            fw[d][fn[d]] = din[d];
            fn[d]++;
          end
          open_f[d]     = 1'b1;
          ready_from[d] = k + DW[d] - 1;
          if (lst[d]) end_edge[d] = k + DW[d] - 1;
        end
        if (end_edge[d] == k) begin
          r         = ref_crc(d);
          eo[d]     = r ^ XO[d];
          eok[d]    = (r == RS[d]);
          ev[d]     = 1'b1;
          fn[d]     = 0;
          open_f[d] = 1'b0;
          end_edge[d] = -1;
        end
      end
    end
  end

  // Compare: every falling edge, every output of every instance against the model.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        chk("rst_in_ready", d, rdy[d], 1);
        chk("rst_busy", d, bsy[d], 0);
        chk("rst_crc_valid", d, cv[d], 0);
        chk("rst_crc_out", d, ov[d], 0);
        chk("rst_crc_ok", d, ok[d], 0);
      end else begin
        chk("in_ready", d, rdy[d], (k >= ready_from[d]));
        chk("busy", d, bsy[d], open_f[d]);
        chk("crc_valid", d, cv[d], ev[d]);
        chk("crc_out", d, ov[d], eo[d]);
        chk("crc_ok", d, ok[d], eok[d]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one word and hold it until the model says it was taken; returns the accept edge.
  task automatic send(input int d, input logic [31:0] w, input bit l, output int acc_e);
    int n;
    bit wr;
    n = 0;
    din[d] = w; vld[d] = 1'b1; lst[d] = l;
    do begin
      wr = (k >= ready_from[d]);
      @(posedge clk);
      #1;
      n++;
    end while (!wr && n < 200);
    if (!wr) timeout("accept", d);
    vld[d] = 1'b0; lst[d] = 1'b0;
    acc_e = k;
  endtask

  // Wait for the DUT's crc_valid and check literal result and latency.
  task automatic expect_crc(input int d, input bit use_lit, input logic [31:0] lit, input int ok_exp,
                            input int acc_e, input int lat);
    int n;
    n = 0;
    while (!cv[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cv[d]) timeout("crc_valid_wait", d);
    else begin
      if (use_lit) chk("crc_literal", d, ov[d], lit);
      if (ok_exp >= 0) chk("crc_ok_literal", d, ok[d], ok_exp);
      if (lat >= 0) chk("latency", d, k - acc_e, lat);
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] s [64];
  logic [31:0] m [64];

  initial begin
    int e, e0, e1, idx, pulses;
    rst_n = 1'b0; clr = '0; vld = '0; lst = '0;
    for (int d = 0; d < 3; d++) din[d] = '0;
    for (int i = 0; i < 64; i++) begin s[i] = '0; m[i] = '0; end
    for (int i = 0; i < 9; i++) s[i] = 32'h31 + i;

    // Pin the model against hand-known CRC values.
    m[0] = 32'h01;
    chk("pin_crc8_01", 0, crc_of(8, 32'h07, 0, 8, m, 1), 32'h07);
    m[0] = 32'hFF;
    chk("pin_crc8_ff", 0, crc_of(8, 32'h07, 0, 8, m, 1), 32'hF3);
    chk("pin_crc8_str", 0, crc_of(8, 32'h07, 0, 8, s, 9), 32'hF4);
    chk("pin_crc16_str", 1, crc_of(16, 32'h1021, 32'hFFFF, 8, s, 9), 32'h29B1);
    for (int i = 0; i < 8; i++) m[i] = 32'h1;
    chk("pin_crc8_bits", 2, crc_of(8, 32'h07, 0, 1, m, 8), 32'hF3);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);

    // Single-byte frames.
    send(0, 32'h01, 1, e); expect_crc(0, 1, 32'h07, 0, e, 7);
    send(0, 32'hFF, 1, e); expect_crc(0, 1, 32'hF3, 0, e, 7);
    send(0, 32'h00, 1, e); expect_crc(0, 1, 32'h00, 1, e, 7);

    // "123456789" back-to-back: 72 cycles from first accept to crc_valid.
    send(0, s[0], 0, e0);
    for (int i = 1; i < 9; i++) send(0, s[i], i == 8, e);
    chk("burst_span", 0, e - e0, 64);
    expect_crc(0, 1, 32'hF4, 0, e0, 71);

    // CRC-16 CCITT and residue check.
    for (int i = 0; i < 9; i++) send(1, s[i], i == 8, e);
    expect_crc(1, 1, 32'h29B1, 0, e, 7);
    for (int i = 0; i < 9; i++) m[i] = s[i];
    m[9] = 32'h29; m[10] = 32'hB1;
    for (int i = 0; i < 11; i++) send(1, m[i], i == 10, e);
    expect_crc(1, 1, 32'h0000, 1, e, 7);
    for (int t = 0; t < 3; t++) begin
      idx = $urandom_range(0, 10);
      m[idx] = m[idx] ^ 32'($urandom_range(1, 255));
      for (int i = 0; i < 11; i++) send(1, m[i], i == 10, e);
      expect_crc(1, 0, 0, 0, e, 7);
      for (int i = 0; i < 9; i++) m[i] = s[i];
      m[9] = 32'h29; m[10] = 32'hB1;
    end

    // Bit-serial 0xFF with random idle gaps.
    for (int i = 0; i < 8; i++) begin
      tick($urandom_range(0, 4));
      send(2, 32'h1, i == 7, e);
    end
    expect_crc(2, 1, 32'hF3, 0, e, 0);

    // Abort after three bytes, then the full string.
    for (int i = 0; i < 3; i++) send(0, s[i], 0, e);
    tick(2);
    clr[0] = 1'b1;
    tick(1);
    clr[0] = 1'b0;
    for (int i = 0; i < 9; i++) send(0, s[i], i == 8, e);
    expect_crc(0, 1, 32'hF4, 0, e, 7);

    // Back-to-back frames: next frame's first byte taken in the crc_valid cycle.
    for (int i = 0; i < 9; i++) send(0, s[i], i == 8, e1);
    send(0, 32'h01, 1, e);
    chk("no_bubble", 0, e - e1, 8);
    expect_crc(0, 1, 32'h07, 0, e, 7);

    // Randomized frames with random gaps on all instances.
    for (int f = 0; f < 24; f++) begin
      int d, len;
      d   = $urandom_range(0, 2);
      len = (d == 2) ? $urandom_range(1, 16) : $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        tick($urandom_range(0, 3));
        send(d, $urandom, i == len - 1, e);
      end
      expect_crc(d, 0, 0, -1, e, DW[d] - 1);
    end

    // Asynchronous reset in the middle of shifting a last word: no crc_valid may follow.
    send(0, 32'hA5, 1, e);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 0, bsy[0], 0);
    chk("async_rst_crc_out", 0, ov[0], 0);
    chk("async_rst_in_ready", 0, rdy[0], 1);
    tick(2);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cv[0]) pulses++;
    end
    chk("no_valid_after_rst", 0, pulses, 0);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog at edge %0d: simulation did not finish", k);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crc_stream_engine.md
# crc_stream_engine

Parametrised, bit-serial streaming CRC generator/checker for the LED matrix controller's frame path. It accepts DATA_W-bit words over a valid/ready handshake and folds each word into a CRC_W-bit remainder, MSB first, one bit per clock. Frames are delimited by `in_last`. At frame end it presents the final CRC and a residue-match flag, so one block serves both TX generation and RX checking of pixel/command frames. It generalises the fixed 8-bit combinational CRC with a configurable polynomial, init value, output XOR, data width and multi-word framing.

## Interface
- CRC_W, 8, remainder width in bits (2..32).
- DATA_W, 8, input word width in bits (1..32).
- POLY, 8'h07, generator polynomial; implicit x^CRC_W term omitted.
- INIT, 0, remainder value at reset, at frame start and after `clr`.
- XOR_OUT, 0, XOR applied to the remainder to form `crc_out`.
- RESIDUE, 0, expected raw remainder after a frame that ends with its own CRC appended; compared to set `crc_ok`.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous abort: drop the current frame and return to IDLE.
- in_data  in  DATA_W  word to fold in; consumed MSB first.
- in_valid  in  1  `in_data`/`in_last` are valid.
- in_last  in  1  accepted word is the final word of the frame.
- in_ready  out  1  engine can accept a word this cycle.
- busy  out  1  frame in progress (state is not IDLE).
- crc_out  out  CRC_W  final CRC: remainder ^ XOR_OUT; held until the next frame end.
- crc_ok  out  1  raw remainder == RESIDUE; updated together with `crc_out`.
- crc_valid  out  1  one-cycle pulse; `crc_out`/`crc_ok` were just updated.

## Operation
- Bit step with input bit b: fb = rem[CRC_W-1] ^ b; rem = {rem[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0). No reflection. All arithmetic is truncated to CRC_W bits.
- States:
  - IDLE: rem = INIT, in_ready = 1.
  - SHIFT: bits of the current word remain, in_ready = 0.
  - GAP: mid-frame, waiting for the next word, in_ready = 1.
- Accept = in_valid & in_ready.
  - On the accept edge, in_data[DATA_W-1] is folded in, the remaining DATA_W-1 bits are loaded into a shift register, and the bit counter is set to DATA_W-1.
  - SHIFT folds one bit per edge. When the counter reaches 0, the next state is GAP, or IDLE if the word was flagged last.
  - DATA_W = 1: SHIFT is never entered; in_ready stays 1.
- Frame end, on the edge that folds the final bit of the last word:
  - crc_out <= rem_next ^ XOR_OUT.
  - crc_ok <= (rem_next == RESIDUE).
  - crc_valid <= 1.
  - rem <= INIT; state <= IDLE.
- in_last is sampled only on the accept edge; ignored otherwise. in_data must be stable only on the accept edge.
- clr has priority over everything:
  - next state IDLE, rem = INIT, shift register and counter cleared, crc_valid = 0.
  - crc_out and crc_ok keep their previous values.
  - Any word presented in the clr cycle is not accepted.
- Asynchronous reset, mid-frame or otherwise: identical effect to clr, plus crc_out = 0 and crc_ok = 0.

## Timing
- Reset values: in_ready = 1, busy = 0, crc_valid = 0, crc_out = 0, crc_ok = 0, rem = INIT, state IDLE.
- Throughput: one word per DATA_W cycles under back-to-back in_valid. in_ready is low for exactly DATA_W-1 cycles after each accept.
- Latency: last word accepted at edge T → crc_valid high for the single cycle after edge T+DATA_W-1.
- In the crc_valid cycle in_ready = 1. A new frame's first word may be accepted in that cycle with no bubble.
- busy rises after the first accept edge and falls on the frame-end edge.
- Single-word frame with DATA_W = 1: accept and frame end occur on the same edge.

## Test plan
- CRC_W=8, POLY=07, DATA_W=8, INIT=0: single words with in_last=1.
  - 0x01 → crc_out 0x07.
  - 0xFF → crc_out 0xF3.
  - 0x00 → crc_out 0x00.
  - In each case crc_valid pulses exactly 8 cycles after accept.
- Same config, ASCII "123456789" back-to-back (in_valid held high) → crc_out 0xF4.
  - in_ready low 7 of every 8 cycles.
  - Total 72 cycles from first accept to crc_valid.
- CRC_W=16, POLY=1021, INIT=FFFF, DATA_W=8, "123456789" → crc_out 0x29B1.
  - Then send 31 32 ... 39 29 B1 as a new frame (RESIDUE=0) → crc_ok=1.
  - Corrupting any byte of that frame → crc_ok=0.
- DATA_W=1, CRC_W=8, POLY=07: bits of 0xFF MSB first, with idle gaps of random length (in_valid low) between bits → crc_out 0xF3.
  - in_ready never drops.
- Abort and reset:
  - Pulse clr after 3 bytes of "123456789", then send the full string → 0xF4.
  - Assert rst_n low mid-SHIFT → all outputs take reset values immediately, and no crc_valid occurs.
- Back-to-back frames: accept the next frame's first byte in the crc_valid cycle → both CRCs are correct, with no lost cycle.
